// File: rtl/button_encoder_pkg.sv
// Shared types and helpers for the player-input front end.
package button_encoder_pkg;

  localparam int unsigned NUM_COLOURS = 4;

  // Encoder FSM state codes, kept alongside the controller state codes.
  typedef enum logic [1:0] {
    BTN_IDLE_S    = 2'd0,
    BTN_HELD_S    = 2'd1,
    BTN_BLOCKED_S = 2'd2
  } btn_state_e;

  // True when exactly one colour button is down.
  function automatic logic is_onehot(input logic [NUM_COLOURS-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Index of the (single) set bit; 0 when none is set.
  function automatic logic [1:0] onehot_index(input logic [NUM_COLOURS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_COLOURS; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_encoder_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw input.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous input into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing cycles; flip the level once the count
  // has reached DEBOUNCE_CYCLES and the input still disagrees.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/button_encoder.sv
// Debounces four colour buttons and a start button, and encodes a single
// clean colour press into IN / IN_VALID for the game controller.
module button_encoder
  import button_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic       BTN_START,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       START_GAME,
  output logic       ERR
);

  logic [NUM_COLOURS-1:0] w_db;
  logic                   w_db_start;
  logic                   w_onehot;
  logic [1:0]             w_idx;

  btn_state_e r_state;
  logic [1:0] r_in;
  logic       r_in_valid;
  logic       r_err;

  for (genvar k = 0; k < NUM_COLOURS; k++) begin : g_colour_db
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_raw  (BTN[k]),
      .o_level(w_db[k])
    );
  end

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_start (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_raw  (BTN_START),
    .o_level(w_db_start)
  );

  assign w_onehot = is_onehot(w_db);
  assign w_idx    = onehot_index(w_db);

  // Accept one colour per press/release cycle; reject multi-button presses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= BTN_IDLE_S;
      r_in       <= '0;
      r_in_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        BTN_IDLE_S: begin
          if (w_db != '0) begin
            if (w_onehot) begin
              r_in       <= w_idx;
              r_in_valid <= 1'b1;
              r_state    <= BTN_HELD_S;
            end else begin
              r_err   <= 1'b1;
              r_state <= BTN_BLOCKED_S;
            end
          end
        end
        BTN_HELD_S: begin
          if (w_db == '0) begin
            r_in_valid <= 1'b0;
            r_state    <= BTN_IDLE_S;
          end
        end
        BTN_BLOCKED_S: begin
          r_in_valid <= 1'b0;
          if (w_db == '0) r_state <= BTN_IDLE_S;
        end
        default: begin
          r_in_valid <= 1'b0;
          r_state    <= BTN_IDLE_S;
        end
      endcase
    end
  end

  assign IN         = r_in;
  assign IN_VALID   = r_in_valid;
  assign START_GAME = w_db_start;
  assign ERR        = r_err;

endmodule

// File: tb/tb_button_encoder.sv
// Directed, table-driven bench for button_encoder with DEBOUNCE_CYCLES = 4.
// Raw edge to debounced edge is 7 cycles; IN_VALID / ERR follow at 8.
module tb_button_encoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] BTN;
  logic       BTN_START;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       START_GAME;
  logic       ERR;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] btn;
    logic       start;
    int         ncyc;
    logic       exp_valid;
    logic [1:0] exp_in;
    logic       exp_start;
    int         exp_errs;
  } seg_t;

  seg_t segs[$];

  button_encoder #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN       (BTN),
    .BTN_START (BTN_START),
    .IN        (IN),
    .IN_VALID  (IN_VALID),
    .START_GAME(START_GAME),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (ERR) err_seen++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic [3:0] btn,
                     input logic start, input int ncyc, input logic ev,
                     input logic [1:0] ein, input logic es, input int ee);
    seg_t s;
    s.name = name; s.rst = rst; s.btn = btn; s.start = start; s.ncyc = ncyc;
    s.exp_valid = ev; s.exp_in = ein; s.exp_start = es; s.exp_errs = ee;
    segs.push_back(s);
  endtask

  initial begin
    RST = 1'b1; BTN = '0; BTN_START = 1'b0;

    //   name            rst btn      st  cyc vld in  st  errs
    add("reset",         1, 4'b0000, 0,  2, 0, 2'd0, 0, 0);
    add("idle",          0, 4'b0000, 0,  3, 0, 2'd0, 0, 0);
    // Clean press of colour 2
    add("clean_pre",     0, 4'b0100, 0,  7, 0, 2'd0, 0, 0);
    add("clean_rise",    0, 4'b0100, 0,  1, 1, 2'd2, 0, 0);
    add("clean_hold",    0, 4'b0100, 0, 12, 1, 2'd2, 0, 0);
    add("clean_rel_pre", 0, 4'b0000, 0,  7, 1, 2'd2, 0, 0);
    add("clean_fall",    0, 4'b0000, 0,  1, 0, 2'd2, 0, 0);
    add("clean_idle",    0, 4'b0000, 0,  4, 0, 2'd2, 0, 0);
    // Bounce on colour 1: 2-cycle runs never reach the counter limit
    add("bounce_h1",     0, 4'b0010, 0,  2, 0, 2'd2, 0, 0);
    add("bounce_l1",     0, 4'b0000, 0,  2, 0, 2'd2, 0, 0);
    add("bounce_h2",     0, 4'b0010, 0,  2, 0, 2'd2, 0, 0);
    add("bounce_l2",     0, 4'b0000, 0,  2, 0, 2'd2, 0, 0);
    add("bounce_h3",     0, 4'b0010, 0,  2, 0, 2'd2, 0, 0);
    add("bounce_l3",     0, 4'b0000, 0,  2, 0, 2'd2, 0, 0);
    add("bounce_pre",    0, 4'b0010, 0,  7, 0, 2'd2, 0, 0);
    add("bounce_rise",   0, 4'b0010, 0,  1, 1, 2'd1, 0, 0);
    add("bounce_rel_pre",0, 4'b0000, 0,  7, 1, 2'd1, 0, 0);
    add("bounce_fall",   0, 4'b0000, 0,  1, 0, 2'd1, 0, 0);
    add("bounce_idle",   0, 4'b0000, 0,  4, 0, 2'd1, 0, 0);
    // Dual press: reject once, no IN_VALID, then a clean colour 3
    add("dual_pre",      0, 4'b1001, 0,  7, 0, 2'd1, 0, 0);
    add("dual_err",      0, 4'b1001, 0,  1, 0, 2'd1, 0, 1);
    add("dual_hold",     0, 4'b1001, 0, 12, 0, 2'd1, 0, 0);
    add("dual_rel",      0, 4'b0000, 0, 12, 0, 2'd1, 0, 0);
    add("c3_pre",        0, 4'b1000, 0,  7, 0, 2'd1, 0, 0);
    add("c3_rise",       0, 4'b1000, 0,  1, 1, 2'd3, 0, 0);
    add("c3_rel",        0, 4'b0000, 0, 12, 0, 2'd3, 0, 0);
    // Late extra button is ignored while held
    add("late_pre",      0, 4'b0001, 0,  7, 0, 2'd3, 0, 0);
    add("late_rise",     0, 4'b0001, 0,  3, 1, 2'd0, 0, 0);
    add("late_extra",    0, 4'b0101, 0, 10, 1, 2'd0, 0, 0);
    add("late_rel0",     0, 4'b0100, 0, 10, 1, 2'd0, 0, 0);
    add("late_rel2_pre", 0, 4'b0000, 0,  7, 1, 2'd0, 0, 0);
    add("late_fall",     0, 4'b0000, 0,  1, 0, 2'd0, 0, 0);
    add("late_idle",     0, 4'b0000, 0,  4, 0, 2'd0, 0, 0);
    // Start button: 7-cycle latency on both edges
    add("start_pre",     0, 4'b0000, 1,  6, 0, 2'd0, 0, 0);
    add("start_rise",    0, 4'b0000, 1,  1, 0, 2'd0, 1, 0);
    add("start_hold",    0, 4'b0000, 1, 13, 0, 2'd0, 1, 0);
    add("start_rel_pre", 0, 4'b0000, 0,  6, 0, 2'd0, 1, 0);
    add("start_fall",    0, 4'b0000, 0,  1, 0, 2'd0, 0, 0);
    add("start_idle",    0, 4'b0000, 0,  4, 0, 2'd0, 0, 0);

    foreach (segs[i]) begin
      RST = segs[i].rst; BTN = segs[i].btn; BTN_START = segs[i].start;
      err_seen = 0;
      for (int c = 0; c < segs[i].ncyc; c++) tick();
      chk({segs[i].name, ".IN_VALID"},   int'(IN_VALID),   int'(segs[i].exp_valid));
      chk({segs[i].name, ".IN"},         int'(IN),         int'(segs[i].exp_in));
      chk({segs[i].name, ".START_GAME"}, int'(START_GAME), int'(segs[i].exp_start));
      chk({segs[i].name, ".ERR_count"},  err_seen,         segs[i].exp_errs);
    end

    // Reset mid-press: outputs clear at once, then the held button re-debounces.
    begin
      int vld_hi;
      BTN = 4'b0100; err_seen = 0;
      for (int c = 0; c < 8; c++) tick();
      chk("rstmid.pre_valid", int'(IN_VALID), 1);
      chk("rstmid.pre_in", int'(IN), 2);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rstmid.valid_cleared", int'(IN_VALID), 0);
      chk("rstmid.in_cleared", int'(IN), 0);
      vld_hi = 0;
      for (int c = 0; c < 7; c++) begin
        tick();
        if (IN_VALID) vld_hi++;
      end
      chk("rstmid.no_early_valid", vld_hi, 0);
      tick();
      chk("rstmid.re_rise_valid", int'(IN_VALID), 1);
      chk("rstmid.re_rise_in", int'(IN), 2);
      chk("rstmid.err_count", err_seen, 0);
      BTN = '0;
      for (int c = 0; c < 12; c++) tick();
      chk("rstmid.released", int'(IN_VALID), 0);
    end

    // Counter boundary: a 4-cycle glitch is filtered, a 5-cycle pulse passes.
    begin
      int vld_hi;
      int rise_at;
      vld_hi = 0;
      BTN = 4'b0001;
      for (int c = 0; c < 4; c++) tick();
      BTN = '0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (IN_VALID) vld_hi++;
      end
      chk("glitch4.filtered", vld_hi, 0);

      rise_at = -1; vld_hi = 0;
      BTN = 4'b0010;
      for (int c = 1; c <= 5; c++) begin
        tick();
        if (IN_VALID) vld_hi++;
      end
      BTN = '0;
      for (int c = 6; c <= 20; c++) begin
        tick();
        if (IN_VALID) begin
          vld_hi++;
          if (rise_at < 0) rise_at = c;
        end
      end
      chk("pulse5.rise_cycle", rise_at, 8);
      chk("pulse5.high_cycles", vld_hi, 5);
      chk("pulse5.in", int'(IN), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
